// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 LED panel row scanner with binary code modulation.
// Shifts one bit-plane per row from a synchronous framebuffer, then latches and shows it for BASE_ON<<plane cycles.
module hub75_bcm_scanner #(
    parameter int COLS = 64,
    parameter int ROW_BITS = 5,
    parameter int COLOR_BITS = 4,
    parameter int BASE_ON = 8,
    localparam int COL_BITS = $clog2(COLS),
    localparam int PW = 6 * COLOR_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic [ROW_BITS+COL_BITS-1:0] pix_addr,
    input  logic [PW-1:0]                pix_data,
    output logic                         r0,
    output logic                         g0,
    output logic                         b0,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic [ROW_BITS-1:0]          addr,
    output logic                         clk_out,
    output logic                         latch,
    output logic                         oe,
    output logic                         frame_start
);
    localparam int PLB = COLOR_BITS > 1 ? $clog2(COLOR_BITS) : 1;
    localparam int DW = COLOR_BITS - 1 + $clog2(BASE_ON + 1);
    localparam int CW = COL_BITS + 2;
    localparam logic [CW-1:0] LAST = CW'(2 * COLS);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    state_t                state;
    logic [ROW_BITS-1:0]   row;
    logic [PLB-1:0]        plane;
    logic [COL_BITS-1:0]   col;
    logic [CW-1:0]         cnt;
    logic [DW-1:0]         dcnt;
    logic [5:0]            bits;
    logic                  last_plane;

    // row/col are flops, so the framebuffer address is glitch-free
    assign pix_addr = {row, col};
    assign last_plane = plane == PLB'(COLOR_BITS - 1);

    genvar c;
    for (c = 0; c < 6; c++) begin : g_ch
        logic [COLOR_BITS-1:0] ch;
        assign ch = pix_data[c*COLOR_BITS +: COLOR_BITS];
        assign bits[c] = ch[plane];
    end

    // pix_addr is already {row,0} on SHIFT entry, so data for column 0 arrives during cycle 0
    // and each column's RGB lands together with the falling clk_out edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row <= '0;
            plane <= '0;
            col <= '0;
            cnt <= '0;
            dcnt <= '0;
            {b1, g1, r1, b0, g0, r0} <= '0;
            addr <= '0;
            clk_out <= 1'b0;
            latch <= 1'b0;
            oe <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= SHIFT;
                        cnt <= '0;
                        frame_start <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= BLANK;
                        clk_out <= 1'b0;
                        addr <= row;
                    end else if (cnt[0]) begin
                        clk_out <= 1'b1;
                    end else begin
                        clk_out <= 1'b0;
                        col <= col + 1'b1;
                        {b1, g1, r1, b0, g0, r0} <= bits;
                    end
                end
                BLANK: begin
                    state <= LATCH;
                    latch <= 1'b1;
                end
                LATCH: begin
                    state <= DISPLAY;
                    latch <= 1'b0;
                    oe <= 1'b0;
                    dcnt <= (DW'(BASE_ON) << plane) - DW'(1);
                    plane <= last_plane ? '0 : plane + 1'b1;
                    row <= row + ROW_BITS'(last_plane);
                end
                DISPLAY: begin
                    if (dcnt == '0) begin
                        oe <= 1'b1;
                        cnt <= '0;
                        if (enable) begin
                            state <= SHIFT;
                            frame_start <= row == '0 && plane == '0;
                        end else begin
                            state <= IDLE;
                            row <= '0;
                            plane <= '0;
                        end
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
